// File: rtl/riscv_icache_refill_ctrl.sv
// Instruction-cache miss/refill controller: stalls the core on a fetch miss, fetches the
// 16-byte block from IRAM (with timeout retry), writes it into the cache arrays, releases stall.
module riscv_icache_refill_ctrl #(
  parameter int unsigned DATA_WIDTH  = 128,
  parameter int unsigned CACHE_SIZE  = 4 * (2 ** 10),
  parameter int unsigned MEM_SIZE    = 4 * CACHE_SIZE,
  parameter int unsigned DATAPBLOCK  = 16,
  parameter int unsigned CACHE_DEPTH = CACHE_SIZE / DATAPBLOCK,
  parameter int unsigned ADDR        = $clog2(MEM_SIZE),
  parameter int unsigned BYTE_OFF    = $clog2(DATAPBLOCK),
  parameter int unsigned INDEX       = $clog2(CACHE_DEPTH),
  parameter int unsigned TAG         = ADDR - BYTE_OFF - INDEX,
  parameter int unsigned S_ADDR      = ADDR - BYTE_OFF,
  parameter int unsigned TIMEOUT_CYC = 64
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  cpu_req_i,
  input  logic [ADDR-1:0]       cpu_addr_i,
  input  logic                  tag_hit_i,
  output logic                  stall_o,
  output logic                  mem_rden_o,
  output logic [S_ADDR-1:0]     mem_addr_o,
  input  logic                  mem_ready_i,
  input  logic [DATA_WIDTH-1:0] mem_data_i,
  output logic                  fill_en_o,
  output logic [INDEX-1:0]      fill_index_o,
  output logic [TAG-1:0]        fill_tag_o,
  output logic [DATA_WIDTH-1:0] fill_data_o,
  output logic [31:0]           miss_cnt_o
);

  localparam int unsigned TmoW = $clog2(TIMEOUT_CYC);
  localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {StIdle, StMiss, StRetry, StFill, StResume} state_e;

  state_e                state_q, state_d;
  logic [S_ADDR-1:0]     req_addr_q, req_addr_d;
  logic [TmoW-1:0]       tmo_q, tmo_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [31:0]           miss_cnt_q, miss_cnt_d;
  logic                  miss;
  logic                  unused_addr_bits;

  assign miss             = cpu_req_i & ~tag_hit_i;
  assign unused_addr_bits = ^cpu_addr_i[BYTE_OFF-1:0];

  always_comb begin
    state_d    = state_q;
    req_addr_d = req_addr_q;
    tmo_d      = tmo_q;
    data_d     = data_q;
    miss_cnt_d = miss_cnt_q;
    unique case (state_q)
      StIdle: begin
        if (miss) begin
          state_d    = StMiss;
          req_addr_d = cpu_addr_i[ADDR-1:BYTE_OFF];
          tmo_d      = '0;
          if (miss_cnt_q != '1) miss_cnt_d = miss_cnt_q + 32'd1;
        end
      end
      StMiss: begin
        // A ready pulse on the terminal timeout cycle still completes the fill.
        if (mem_ready_i) begin
          state_d = StFill;
          data_d  = mem_data_i;
          tmo_d   = '0;
        end else if (tmo_q == TmoLast) begin
          state_d = StRetry;
          tmo_d   = '0;
        end else begin
          tmo_d = tmo_q + TmoW'(1);
        end
      end
      StRetry:  state_d = StMiss;
      StFill:   state_d = StResume;
      StResume: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      req_addr_q <= '0;
      tmo_q      <= '0;
      data_q     <= '0;
      miss_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      req_addr_q <= req_addr_d;
      tmo_q      <= tmo_d;
      data_q     <= data_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  // The early IDLE stall term is suppressed while reset is held so all outputs read 0.
  assign stall_o      = (state_q != StIdle) | (rst_ni & miss);
  assign mem_rden_o   = (state_q == StMiss);
  assign mem_addr_o   = req_addr_q;
  assign fill_en_o    = (state_q == StFill);
  assign fill_index_o = req_addr_q[INDEX-1:0];
  assign fill_tag_o   = req_addr_q[S_ADDR-1:INDEX];
  assign fill_data_o  = data_q;
  assign miss_cnt_o   = miss_cnt_q;

endmodule

// File: tb/tb_riscv_icache_refill_ctrl.sv
// Self-checking bench for riscv_icache_refill_ctrl: an IRAM responder with programmable latency
// drives each miss; expectations come from transaction-level arithmetic on address and latency.
module tb_riscv_icache_refill_ctrl;

  localparam int ADDR = 14;
  localparam int SA   = 10;
  localparam int DW   = 128;

  logic          clk, rst_ni, cpu_req, tag_hit, stall, mem_rden, mem_ready, fill_en;
  logic [ADDR-1:0] cpu_addr;
  logic [SA-1:0]   mem_addr;
  logic [DW-1:0]   mem_data, fill_data;
  logic [7:0]      fill_index;
  logic [1:0]      fill_tag;
  logic [31:0]     miss_cnt;

  int n_checks, n_fail, exp_cnt;
  // Results of the most recent miss transaction.
  int r_stall, r_rden, r_runs, r_fills, r_gap_first, r_retry_gap, g_low;
  bit r_addr_bad;
  logic [7:0]    r_idx;
  logic [1:0]    r_tag;
  logic [DW-1:0] r_data;

  riscv_icache_refill_ctrl dut (
    .clk_i(clk), .rst_ni(rst_ni), .cpu_req_i(cpu_req), .cpu_addr_i(cpu_addr),
    .tag_hit_i(tag_hit), .stall_o(stall), .mem_rden_o(mem_rden), .mem_addr_o(mem_addr),
    .mem_ready_i(mem_ready), .mem_data_i(mem_data), .fill_en_o(fill_en),
    .fill_index_o(fill_index), .fill_tag_o(fill_tag), .fill_data_o(fill_data),
    .miss_cnt_o(miss_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DW-1:0] rand_blk();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Drives one miss and the IRAM side until the core sees stall drop with a hitting replay.
  // IRAM raises ready on the lat-th consecutive rden cycle (lat1 first attempt, lat2 retries).
  task automatic run_miss(input logic [ADDR-1:0] addr, input int lat1, input int lat2,
                          input logic [DW-1:0] data, input bit stale);
    int run, attempt;
    bit prev, ready, done;
    logic [SA-1:0] blk;
    blk = addr[ADDR-1:4];
    r_stall = 0; r_rden = 0; r_runs = 0; r_fills = 0; r_gap_first = -1; r_retry_gap = 1000;
    r_addr_bad = 0; r_idx = '0; r_tag = '0; r_data = '0;
    run = 0; attempt = 0; prev = 0; done = 0;
    for (int c = 0; c < 400 && !done; c++) begin
      @(negedge clk);
      if (c == 0) begin
        cpu_req = 1'b1; cpu_addr = addr; tag_hit = 1'b0;
      end else begin
        cpu_req = 1'b1; cpu_addr = ADDR'($urandom); tag_hit = 1'b1;
      end
      if (mem_rden) begin
        if (!prev) begin
          attempt++; run = 0; r_runs++;
          if (r_runs == 1) r_gap_first = g_low;
          else if (g_low < r_retry_gap) r_retry_gap = g_low;
        end
        run++; g_low = 0; r_rden++;
        ready = (attempt == 1) ? (run == lat1) : (run == lat2);
        if (mem_addr !== blk) r_addr_bad = 1;
      end else begin
        g_low++;
        ready = stale && ($urandom_range(3) == 0);
      end
      prev      = mem_rden;
      mem_ready = ready;
      mem_data  = (ready && mem_rden) ? data : rand_blk();
      #1;
      if (fill_en) begin
        r_fills++; r_idx = fill_index; r_tag = fill_tag; r_data = fill_data;
      end
      if (stall) r_stall++;
      else if (c > 0) done = 1;
    end
    mem_ready = 1'b0;
    exp_cnt++;
    if (!done) begin
      n_checks++; n_fail++;
      $display("FAIL miss_timeout: stall still high after 400 cycles, addr %0h", addr);
    end
  endtask

  task automatic test_reset();
    bit bad_stall, bad_rden;
    rst_ni = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      cpu_req = 1'($urandom); tag_hit = 1'($urandom); cpu_addr = ADDR'($urandom);
      mem_ready = 1'($urandom); mem_data = rand_blk();
      #1;
      n_checks++;
      if ({stall, mem_rden, mem_addr, fill_en, fill_index, fill_tag, fill_data, miss_cnt} !== '0)
      begin
        n_fail++;
        $display("FAIL reset_outputs: cycle %0d stall=%b rden=%b fill_en=%b miss_cnt=%0d, all 0 required",
                 i, stall, mem_rden, fill_en, miss_cnt);
      end
    end
    @(negedge clk);
    rst_ni = 1'b1; cpu_req = 1'b1; tag_hit = 1'b1; mem_ready = 1'b0;
    bad_stall = 0; bad_rden = 0;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (stall !== 1'b0) bad_stall = 1;
      if (mem_rden !== 1'b0) bad_rden = 1;
      @(negedge clk);
      cpu_addr = ADDR'($urandom);
    end
    n_checks++;
    if (bad_stall) begin n_fail++; $display("FAIL idle_hit_stall: got 1, required 0"); end
    n_checks++;
    if (bad_rden) begin n_fail++; $display("FAIL idle_hit_rden: got 1, required 0"); end
    exp_cnt = 0;
  endtask

  task automatic test_basic_miss();
    logic [DW-1:0] d;
    d = {16{8'hA5}};
    run_miss(14'h1230, 4, 1, d, 1'b0);
    n_checks++;
    if (r_rden !== 4) begin n_fail++; $display("FAIL basic_rden_cycles: got %0d want 4", r_rden); end
    n_checks++;
    if (r_addr_bad) begin n_fail++; $display("FAIL basic_mem_addr: got mismatch want 123"); end
    n_checks++;
    if (r_fills !== 1) begin n_fail++; $display("FAIL basic_fills: got %0d want 1", r_fills); end
    n_checks++;
    if (r_idx !== 8'h23) begin n_fail++; $display("FAIL basic_index: got %0h want 23", r_idx); end
    n_checks++;
    if (r_tag !== 2'h1) begin n_fail++; $display("FAIL basic_tag: got %0h want 1", r_tag); end
    n_checks++;
    if (r_data !== d) begin n_fail++; $display("FAIL basic_data: got %0h want %0h", r_data, d); end
    n_checks++;
    if (r_stall !== 7) begin n_fail++; $display("FAIL basic_stall: got %0d want 7", r_stall); end
    n_checks++;
    if (miss_cnt !== 32'd1) begin n_fail++; $display("FAIL basic_cnt: got %0d want 1", miss_cnt); end
  endtask

  task automatic test_timeout_retry();
    logic [ADDR-1:0] a;
    logic [DW-1:0] d;
    a = ADDR'($urandom); d = rand_blk();
    run_miss(a, 0, 5, d, 1'b0);
    n_checks++;
    if (r_runs !== 2) begin n_fail++; $display("FAIL retry_runs: got %0d want 2", r_runs); end
    n_checks++;
    if (r_retry_gap !== 1) begin
      n_fail++; $display("FAIL retry_gap: got %0d want 1", r_retry_gap);
    end
    n_checks++;
    if (r_rden !== 69) begin n_fail++; $display("FAIL retry_rden: got %0d want 69", r_rden); end
    n_checks++;
    if (r_addr_bad) begin n_fail++; $display("FAIL retry_mem_addr: got mismatch want %0h", a >> 4); end
    n_checks++;
    if (r_fills !== 1 || r_data !== d) begin
      n_fail++; $display("FAIL retry_fill: got %0d fills want 1 with data %0h", r_fills, d);
    end
    n_checks++;
    if (miss_cnt !== 32'(exp_cnt)) begin
      n_fail++; $display("FAIL retry_cnt: got %0d want %0d", miss_cnt, exp_cnt);
    end
  endtask

  task automatic test_reset_mid();
    bit seen;
    @(negedge clk);
    cpu_req = 1'b1; cpu_addr = 14'h0560; tag_hit = 1'b0; mem_ready = 1'b0;
    @(negedge clk);
    cpu_req = 1'b0;
    #1;
    n_checks++;
    if (mem_rden !== 1'b1) begin n_fail++; $display("FAIL mid_rden_before: got %b want 1", mem_rden); end
    @(negedge clk);
    rst_ni = 1'b0;
    @(negedge clk);
    #1;
    n_checks++;
    if ({mem_rden, stall, miss_cnt, mem_addr} !== '0) begin
      n_fail++;
      $display("FAIL mid_reset: rden=%b stall=%b cnt=%0d addr=%0h, all 0 required",
               mem_rden, stall, miss_cnt, mem_addr);
    end
    rst_ni = 1'b1;
    exp_cnt = 0;
    @(negedge clk);
    mem_ready = 1'b1; mem_data = rand_blk();
    @(negedge clk);
    mem_ready = 1'b0;
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      if (fill_en) seen = 1;
      @(negedge clk);
    end
    n_checks++;
    if (seen) begin n_fail++; $display("FAIL mid_stale_fill: got fill_en=1 want 0"); end
  endtask

  task automatic test_back_to_back();
    g_low = 1000;
    run_miss(14'h0100, 3, 1, rand_blk(), 1'b0);
    n_checks++;
    if (r_fills !== 1 || r_idx !== 8'h10 || r_tag !== 2'h0) begin
      n_fail++; $display("FAIL b2b_first: got %0d fills idx %0h want 1 fill idx 10", r_fills, r_idx);
    end
    run_miss(14'h0200, 2, 1, rand_blk(), 1'b0);
    n_checks++;
    if (r_fills !== 1 || r_idx !== 8'h20 || r_tag !== 2'h0) begin
      n_fail++; $display("FAIL b2b_second: got %0d fills idx %0h want 1 fill idx 20", r_fills, r_idx);
    end
    n_checks++;
    if (r_gap_first < 3) begin
      n_fail++; $display("FAIL b2b_rden_gap: got %0d want >= 3", r_gap_first);
    end
    n_checks++;
    if (miss_cnt !== 32'(exp_cnt)) begin
      n_fail++; $display("FAIL b2b_cnt: got %0d want %0d", miss_cnt, exp_cnt);
    end
  endtask

  task automatic test_boundary();
    run_miss(14'h3FFF, 64, 1, rand_blk(), 1'b0);
    n_checks++;
    if (r_idx !== 8'hFF || r_tag !== 2'h3) begin
      n_fail++; $display("FAIL top_addr: got idx %0h tag %0h want ff 3", r_idx, r_tag);
    end
    n_checks++;
    if (r_runs !== 1 || r_rden !== 64) begin
      n_fail++; $display("FAIL terminal_ready: got %0d runs %0d rden want 1 runs 64 rden", r_runs, r_rden);
    end
    n_checks++;
    if (r_stall !== 67 || r_fills !== 1) begin
      n_fail++; $display("FAIL terminal_stall: got %0d stall %0d fills want 67 and 1", r_stall, r_fills);
    end
  endtask

  task automatic test_random();
    logic [ADDR-1:0] a;
    logic [DW-1:0] d;
    int lat1, lat2, blk, e_stall, e_rden, e_runs;
    for (int i = 0; i < 10; i++) begin
      a = ADDR'($urandom); d = rand_blk();
      lat1 = ($urandom_range(3) == 0) ? 0 : int'($urandom_range(20, 1));
      lat2 = int'($urandom_range(10, 1));
      run_miss(a, lat1, lat2, d, 1'b1);
      blk = int'(a) / 16;
      e_runs  = (lat1 == 0) ? 2 : 1;
      e_rden  = (lat1 == 0) ? 64 + lat2 : lat1;
      e_stall = e_rden + e_runs + 2;
      n_checks++;
      if (r_idx !== 8'(blk % 256) || r_tag !== 2'(blk / 256) || r_data !== d || r_fills !== 1) begin
        n_fail++;
        $display("FAIL rand_fill[%0d]: got %0d fills idx %0h tag %0h want idx %0h tag %0h",
                 i, r_fills, r_idx, r_tag, blk % 256, blk / 256);
      end
      n_checks++;
      if (r_rden !== e_rden || r_runs !== e_runs || r_addr_bad) begin
        n_fail++;
        $display("FAIL rand_request[%0d]: got rden %0d runs %0d bad_addr %b want %0d %0d 0",
                 i, r_rden, r_runs, r_addr_bad, e_rden, e_runs);
      end
      n_checks++;
      if (r_stall !== e_stall) begin
        n_fail++; $display("FAIL rand_stall[%0d]: got %0d want %0d", i, r_stall, e_stall);
      end
      n_checks++;
      if (miss_cnt !== 32'(exp_cnt)) begin
        n_fail++; $display("FAIL rand_cnt[%0d]: got %0d want %0d", i, miss_cnt, exp_cnt);
      end
    end
  endtask

  initial begin
    n_checks = 0; n_fail = 0; exp_cnt = 0; g_low = 1000;
    rst_ni = 1'b0; cpu_req = 1'b0; tag_hit = 1'b0; cpu_addr = '0;
    mem_ready = 1'b0; mem_data = '0;
    test_reset();
    test_basic_miss();
    test_timeout_retry();
    test_reset_mid();
    test_back_to_back();
    test_boundary();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
